rx_peak_identification_multi: RTL and testbench



---
 rtl/rx_peak_identification_multi_if.sv | 41 ++++
 rtl/rx_peak_identification_multi.sv | 190 +++++++++++++++++++
 tb/tb_rx_peak_identification_multi.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_peak_identification_multi_if.sv
// Result/acknowledge bundle between the peak finder and the ARM side.
// RX_PEAK_ABS_EN adds o_peak_neg (sign of the winning sample).
interface rx_peak_identification_multi_if #(
  parameter int SEQ_W  = 4,
  parameter int CORR_W = 41,
  parameter int TIME_W = 32
);
  logic                     iack;
  logic signed [CORR_W-1:0] o_peak_value;
  logic signed [CORR_W-1:0] o_second_value;
  logic [SEQ_W-1:0]         o_peak_seq;
  logic [TIME_W-1:0]        o_peak_time;
  logic                     o_peak_unique;
  logic                     o_peak_valid;
  logic                     o_overrun;
`ifdef RX_PEAK_ABS_EN
  logic                     o_peak_neg;

  modport master (
    input  iack,
    output o_peak_value, o_second_value, o_peak_seq, o_peak_time,
    output o_peak_unique, o_peak_valid, o_overrun, o_peak_neg
  );
  modport slave (
    output iack,
    input  o_peak_value, o_second_value, o_peak_seq, o_peak_time,
    input  o_peak_unique, o_peak_valid, o_overrun, o_peak_neg
  );
`else
  modport master (
    input  iack,
    output o_peak_value, o_second_value, o_peak_seq, o_peak_time,
    output o_peak_unique, o_peak_valid, o_overrun
  );
  modport slave (
    output iack,
    input  o_peak_value, o_second_value, o_peak_seq, o_peak_time,
    input  o_peak_unique, o_peak_valid, o_overrun
  );
`endif
endinterface

// File: rtl/rx_peak_identification_multi.sv
// Windowed per-channel peak search with serial best/second scan.
// RX_PEAK_ABS_EN: compare magnitudes and report the winner's sign.
module rx_peak_identification_multi #(
  parameter int NUM_SEQ     = 16,
  parameter int SEQ_W       = 4,
  parameter int CORR_W      = 41,
  parameter int TIME_W      = 32,
  parameter int WINDOW_SIZE = 20400,
  parameter int THRESHOLD   = 800,
  parameter int MARGIN      = 0
) (
  input  logic                      crx_clk,
  input  logic                      rrx_rst_n,
  input  logic                      erx_en,
  input  logic [TIME_W-1:0]         icurrent_time,
  input  logic signed [15:0]        isample_filtered,
  input  logic                      inew_sample_trigger,
  input  logic [NUM_SEQ*CORR_W-1:0] icorrelation_bus,
  rx_peak_identification_multi_if.master res
);
  localparam logic signed [CORR_W-1:0] MIN_V =
    {1'b1, {(CORR_W-1){1'b0}}};
`ifdef RX_PEAK_ABS_EN
  localparam logic signed [CORR_W-1:0] MAX_V =
    {1'b0, {(CORR_W-1){1'b1}}};
  localparam logic signed [CORR_W-1:0] INIT_V = '0;
`else
  localparam logic signed [CORR_W-1:0] INIT_V = MIN_V;
`endif
  localparam logic signed [15:0] THR = 16'(THRESHOLD);
  localparam logic [15:0] WIN_LAST = 16'(WINDOW_SIZE - 1);
  localparam logic [SEQ_W:0] IDX_END = (SEQ_W+1)'(NUM_SEQ);
  localparam logic signed [CORR_W:0] MARG = (CORR_W+1)'(MARGIN);

  typedef enum logic [1:0] {IDLE, SEARCH, SCAN, HOLD} state_t;

  state_t state_q, state_d;

  logic signed [CORR_W-1:0] val   [NUM_SEQ];
  logic signed [CORR_W-1:0] max_q [NUM_SEQ];
  logic [TIME_W-1:0]        ts_q  [NUM_SEQ];
  logic [15:0]              cnt_q;
  logic [SEQ_W:0]           idx_q;
  logic signed [CORR_W-1:0] best_q, second_q, cur;
  logic [SEQ_W-1:0]         bidx_q;
  logic [TIME_W-1:0]        bts_q, cur_ts;
  logic signed [CORR_W:0]   diff;
  logic                     hit, scan_end;
`ifdef RX_PEAK_ABS_EN
  logic [NUM_SEQ-1:0]       neg, neg_q;
  logic                     bneg_q;
`endif

  assign hit      = inew_sample_trigger && (isample_filtered > THR);
  assign scan_end = (idx_q == IDX_END);
  assign cur      = max_q[idx_q[SEQ_W-1:0]];
  assign cur_ts   = ts_q[idx_q[SEQ_W-1:0]];
  assign diff     = {best_q[CORR_W-1], best_q}
                  - {second_q[CORR_W-1], second_q};

  always_comb begin
    for (int k = 0; k < NUM_SEQ; k++) begin
      val[k] = icorrelation_bus[k*CORR_W +: CORR_W];
`ifdef RX_PEAK_ABS_EN
      neg[k] = val[k][CORR_W-1];
      if (val[k] == MIN_V) val[k] = MAX_V;
      else if (neg[k]) val[k] = -val[k];
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (hit) state_d = (WINDOW_SIZE == 1) ? SCAN : SEARCH;
      SEARCH:
        if (inew_sample_trigger && cnt_q == WIN_LAST) state_d = SCAN;
      SCAN:
        if (scan_end) state_d = HOLD;
      HOLD:
        if (res.iack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!erx_en) state_d = IDLE;
  end

  always_ff @(posedge crx_clk or negedge rrx_rst_n) begin
    if (!rrx_rst_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_ff @(posedge crx_clk or negedge rrx_rst_n) begin
    if (!rrx_rst_n) begin
      for (int k = 0; k < NUM_SEQ; k++) begin
        max_q[k] <= '0;
        ts_q[k]  <= '0;
      end
      {cnt_q, idx_q, best_q, second_q, bidx_q, bts_q} <= '0;
      {res.o_peak_value, res.o_second_value} <= '0;
      {res.o_peak_seq, res.o_peak_time}      <= '0;
      {res.o_peak_unique, res.o_peak_valid}  <= '0;
      res.o_overrun <= 1'b0;
`ifdef RX_PEAK_ABS_EN
      {neg_q, bneg_q, res.o_peak_neg} <= '0;
`endif
    end else if (!erx_en) begin
      for (int k = 0; k < NUM_SEQ; k++) begin
        max_q[k] <= '0;
        ts_q[k]  <= '0;
      end
      {cnt_q, idx_q, best_q, second_q, bidx_q, bts_q} <= '0;
      {res.o_peak_value, res.o_second_value} <= '0;
      {res.o_peak_seq, res.o_peak_time}      <= '0;
      {res.o_peak_unique, res.o_peak_valid}  <= '0;
      res.o_overrun <= 1'b0;
`ifdef RX_PEAK_ABS_EN
      {neg_q, bneg_q, res.o_peak_neg} <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          // the opening sample loads unconditionally, so negative peaks survive
          for (int k = 0; k < NUM_SEQ; k++) begin
            max_q[k] <= hit ? val[k] : INIT_V;
            ts_q[k]  <= hit ? icurrent_time : '0;
`ifdef RX_PEAK_ABS_EN
            neg_q[k] <= hit & neg[k];
`endif
          end
          cnt_q <= 16'd1;
          idx_q <= '0;
        end
        SEARCH: begin
          idx_q <= '0;
          if (inew_sample_trigger) begin
            cnt_q <= cnt_q + 16'd1;
            for (int k = 0; k < NUM_SEQ; k++) begin
              if (val[k] > max_q[k]) begin
                max_q[k] <= val[k];
                ts_q[k]  <= icurrent_time;
`ifdef RX_PEAK_ABS_EN
                neg_q[k] <= neg[k];
`endif
              end
            end
          end
        end
        SCAN: begin
          if (scan_end) begin
            res.o_peak_value   <= best_q;
            res.o_second_value <= second_q;
            res.o_peak_seq     <= bidx_q;
            res.o_peak_time    <= bts_q;
            res.o_peak_unique  <= (diff >= MARG);
            res.o_peak_valid   <= 1'b1;
`ifdef RX_PEAK_ABS_EN
            res.o_peak_neg     <= bneg_q;
`endif
          end else begin
            idx_q <= idx_q + 1'b1;
            if (idx_q == '0 || cur > best_q) begin
              second_q <= (idx_q == '0) ? INIT_V : best_q;
              best_q   <= cur;
              bidx_q   <= idx_q[SEQ_W-1:0];
              bts_q    <= cur_ts;
`ifdef RX_PEAK_ABS_EN
              bneg_q   <= neg_q[idx_q[SEQ_W-1:0]];
`endif
            end else if (cur > second_q) begin
              second_q <= cur;
            end
          end
        end
        HOLD: begin
          if (res.iack) begin
            res.o_peak_valid <= 1'b0;
            for (int k = 0; k < NUM_SEQ; k++) begin
              max_q[k] <= INIT_V;
              ts_q[k]  <= '0;
            end
          end
        end
        default: ;
      endcase
      if (hit && (state_q == SCAN || state_q == HOLD))
        res.o_overrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_rx_peak_identification_multi.sv
// Directed + randomized bench for rx_peak_identification_multi.
// Reference model recomputes each window's winner from the raw samples.
module tb_rx_peak_identification_multi;
  localparam int NS = 4, SW = 2, CW = 41, TW = 32;
  localparam int WIN = 8, MARG = 10;

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b1, trig = 1'b0;
  logic [TW-1:0] cur_time = '0;
  logic signed [15:0] filt = '0;
  logic [NS*CW-1:0] bus = '0;

  int checks = 0, errors = 0;
  longint win_v [WIN][NS];
  longint win_t [WIN];
  int     win_f [WIN];
  longint e_val, e_sec, e_time;
  int     e_seq;
  bit     e_uniq, e_neg;

  rx_peak_identification_multi_if #(
    .SEQ_W(SW), .CORR_W(CW), .TIME_W(TW)
  ) res ();

  rx_peak_identification_multi #(
    .NUM_SEQ(NS), .SEQ_W(SW), .CORR_W(CW), .TIME_W(TW),
    .WINDOW_SIZE(WIN), .THRESHOLD(800), .MARGIN(MARG)
  ) dut (
    .crx_clk(clk),
    .rrx_rst_n(rst_n),
    .erx_en(en),
    .icurrent_time(cur_time),
    .isample_filtered(filt),
    .inew_sample_trigger(trig),
    .icorrelation_bus(bus),
    .res(res)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic signed [63:0] obs,
                     logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint mag(longint x);
`ifdef RX_PEAK_ABS_EN
    return (x < 0) ? -x : x;
`else
    return x;
`endif
  endfunction

  task automatic model();
    longint m [NS];
    int wi [NS];
    for (int k = 0; k < NS; k++) begin
      m[k] = mag(win_v[0][k]);
      wi[k] = 0;
      for (int w = 1; w < WIN; w++)
        if (mag(win_v[w][k]) > m[k]) begin
          m[k] = mag(win_v[w][k]);
          wi[k] = w;
        end
    end
    e_seq = 0;
    for (int k = 1; k < NS; k++) if (m[k] > m[e_seq]) e_seq = k;
    e_val  = m[e_seq];
    e_time = win_t[wi[e_seq]];
    e_neg  = win_v[wi[e_seq]][e_seq] < 0;
    e_sec  = -(longint'(1) << (CW - 1));
    for (int k = 0; k < NS; k++)
      if (k != e_seq && m[k] > e_sec) e_sec = m[k];
    e_uniq = (e_val - e_sec) >= MARG;
  endtask

  task automatic fill_random(longint r);
    for (int w = 0; w < WIN; w++) begin
      for (int k = 0; k < NS; k++)
        win_v[w][k] = longint'($urandom_range(32'(2 * r))) - r;
      win_t[w] = longint'($urandom);
      win_f[w] = (w == 0) ? 900 : int'($urandom_range(1600)) - 800;
    end
  endtask

  task automatic drive_sample(int w);
    @(negedge clk);
    cur_time = win_t[w][TW-1:0];
    filt = 16'(win_f[w]);
    for (int k = 0; k < NS; k++) bus[k*CW +: CW] = win_v[w][k][CW-1:0];
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
  endtask

  task automatic run_window();
    for (int w = 0; w < WIN; w++) drive_sample(w);
  endtask

  task automatic wait_valid(string tag);
    int c = 0;
    while (!res.o_peak_valid && c < 40) begin
      @(negedge clk);
      c++;
    end
    chk({tag, " latency"}, c, NS + 1);
  endtask

  task automatic check_res(string tag);
    chk({tag, " valid"}, res.o_peak_valid, 1);
    chk({tag, " value"}, res.o_peak_value, e_val);
    chk({tag, " second"}, res.o_second_value, e_sec);
    chk({tag, " seq"}, res.o_peak_seq, e_seq);
    chk({tag, " time"}, res.o_peak_time, e_time);
    chk({tag, " unique"}, res.o_peak_unique, e_uniq);
`ifdef RX_PEAK_ABS_EN
    chk({tag, " neg"}, res.o_peak_neg, e_neg);
`endif
  endtask

  task automatic ack();
    @(negedge clk);
    res.iack = 1'b1;
    @(negedge clk);
    res.iack = 1'b0;
    chk("ack drop", res.o_peak_valid, 0);
  endtask

  task automatic window_and_check(string tag);
    model();
    run_window();
    wait_valid(tag);
    check_res(tag);
  endtask

  initial begin
    res.iack = 1'b0;
    #12;
    chk("rst valid", res.o_peak_valid, 0);
    chk("rst value", res.o_peak_value, 0);
    chk("rst overrun", res.o_overrun, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // single dominant channel
    fill_random(200);
    win_v[3][2] = 500;
    win_t[3] = 64'h1234;
    win_v[5][0] = 200;
    window_and_check("t1");
    chk("t1 seq2", res.o_peak_seq, 2);
    chk("t1 v500", res.o_peak_value, 500);
    chk("t1 s200", res.o_second_value, 200);
    repeat (3) @(negedge clk);
    chk("t1 hold", res.o_peak_value, e_val);
    ack();

    // tie resolves to the lower index
    fill_random(200);
    win_v[2][1] = 300;
    win_v[6][3] = 300;
    window_and_check("t2");
    chk("t2 seq1", res.o_peak_seq, 1);
    chk("t2 uniq0", res.o_peak_unique, 0);
    repeat (4) @(negedge clk);
    chk("t2 hold", res.o_second_value, 300);
    ack();

    // all-negative correlations
    for (int w = 0; w < WIN; w++) begin
      win_v[w][0] = -50 - longint'($urandom_range(100));
      for (int k = 1; k < NS; k++)
        win_v[w][k] = -70 - longint'($urandom_range(100));
      win_t[w] = longint'($urandom);
      win_f[w] = (w == 0) ? 900 : 0;
    end
    win_v[2][0] = -50;
    win_v[1][1] = -70;
    win_v[5][2] = -70;
    win_v[6][3] = -70;
    win_v[4][3] = -400;
    window_and_check("t3");
`ifdef RX_PEAK_ABS_EN
    chk("t3 abs seq", res.o_peak_seq, 3);
    chk("t3 abs val", res.o_peak_value, 400);
`else
    chk("t3 seq", res.o_peak_seq, 0);
    chk("t3 val", res.o_peak_value, -50);
`endif
    ack();

    for (int n = 0; n < 5; n++) begin
      fill_random(longint'(1) << 20);
      window_and_check("rand");
      ack();
    end

    // re-crossings inside the window, then overrun while holding
    fill_random(1000);
    win_f[3] = 1000;
    win_f[5] = 1000;
    window_and_check("t4");
    win_f[0] = 900;
    drive_sample(0);
    chk("t4 overrun", res.o_overrun, 1);
    chk("t4 still valid", res.o_peak_valid, 1);
    ack();
    fill_random(5000);
    window_and_check("t4b");
    chk("t4 sticky", res.o_overrun, 1);
    ack();

    // enable dropped mid-window discards the partial maxima
    fill_random(longint'(1) << 30);
    for (int w = 0; w < 5; w++) drive_sample(w);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    chk("t5 valid", res.o_peak_valid, 0);
    chk("t5 value", res.o_peak_value, 0);
    chk("t5 second", res.o_second_value, 0);
    chk("t5 time", res.o_peak_time, 0);
    chk("t5 overrun", res.o_overrun, 0);
    fill_random(1000);
    window_and_check("t5b");
    ack();

    // asynchronous reset while scanning
    fill_random(3000);
    run_window();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6 async value", res.o_peak_value, 0);
    chk("t6 async seq", res.o_peak_seq, 0);
    chk("t6 async time", res.o_peak_time, 0);
    @(negedge clk);
    rst_n = 1'b1;
    win_f[0] = 500;
    drive_sample(0);
    repeat (12) @(negedge clk);
    chk("t6 no start", res.o_peak_valid, 0);
    win_f[0] = 900;
    window_and_check("t6b");
    ack();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
